mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//   Memory-side responder for the multicycle MIPS byte-wide memory bus. Serves the
//   core's memwrite/addr/writedata requests from an on-chip byte RAM with registered reads.
//   After reset, a boot-load streaming port fills the RAM while the CPU is held in reset,
//   then releases the CPU. Sits beside the mips core at SoC top level.
// PARAMETERS
//   BUS_WIDTH          32            width of CPU address bus
//   MEM_DATA_BUS_WIDTH 8             width of the memory data byte lanes
//   ADDR_BITS          10            RAM index width; MEM_BYTES = 2**ADDR_BITS
//   MMIO_ADDR          32'hFFFF_FFFC output-port address, used only with MIPS_MEM_MMIO_EN
// PORTS
//   clk_in          in   1                   single clock; all state updates on rising edge
//   reset_in        in   1                   asynchronous, active-low reset
//   memwrite_in     in   1                   CPU write strobe
//   addr_in         in   BUS_WIDTH           CPU byte address
//   writedata_in    in   MEM_DATA_BUS_WIDTH  CPU write byte
//   memdata_out     out  MEM_DATA_BUS_WIDTH  read byte to CPU, registered
//   load_valid_in   in   1                   boot byte valid
//   load_data_in    in   MEM_DATA_BUS_WIDTH  boot byte
//   load_last_in    in   1                   marks final boot byte
//   load_ready_out  out  1                   responder accepts boot byte
//   cpu_hold_out    out  1                   1 = hold CPU in reset (top-level ties to core reset)
//   load_count_out  out  ADDR_BITS+1         bytes accepted during load
//   error_out       out  1                   sticky: overflow or out-of-range access
//   io_out          out  MEM_DATA_BUS_WIDTH  MMIO output register
//   io_strobe_out   out  1                   one-cycle pulse on MMIO write
// BEHAVIOUR
//   Reset (reset_in=0, async): state=S_LOAD, ptr=0, memdata_out=0, load_ready_out=1,
//     cpu_hold_out=1, load_count_out=0, error_out=0, io_out=0, io_strobe_out=0. RAM not cleared.
//   FSM S_LOAD -> S_RUN; S_RUN is terminal until reset. No other states.
//   S_LOAD: accept = load_valid_in & load_ready_out; on accept mem[ptr]<=load_data_in,
//     ptr++, load_count_out++. CPU inputs ignored; memdata_out held 0.
//     accept with load_last_in=1 -> S_RUN next edge.
//     accept at ptr=MEM_BYTES-1 with load_last_in=0 -> S_RUN, error_out<=1 (overflow).
//     load_valid_in high while load_ready_out low (S_RUN): ignored, no error.
//   Entering S_RUN: load_ready_out=0 and cpu_hold_out=0 on the same edge; count frozen.
//   S_RUN: in-range = addr_in[BUS_WIDTH-1:ADDR_BITS]==0.
//     Read: every edge memdata_out<=mem[addr_in[ADDR_BITS-1:0]]; 1-cycle latency.
//     Write: memwrite_in & in-range -> mem[idx]<=writedata_in at edge.
//     Same-cycle write+read same idx: memdata_out gets OLD byte (read-before-write).
//     Out-of-range: write dropped, memdata_out<=0, error_out<=1 (sticky till reset).
//   Reset asserted mid-load or mid-run: immediate return to reset values; load restarts at 0.
// CONFIGURATION
//   MIPS_MEM_MMIO_EN defined: in S_RUN, addr_in==MMIO_ADDR is not out-of-range;
//     write -> io_out<=writedata_in, io_strobe_out=1 for exactly that cycle after edge;
//     read -> memdata_out<=io_out. RAM untouched.
//   Undefined: io_out and io_strobe_out tied 0; MMIO_ADDR treated as ordinary out-of-range.
// STRUCTURE
//   Shared package mips_pkg: FSM state encodings (S_LOAD, S_RUN), default
//     BUS_WIDTH/MEM_DATA_BUS_WIDTH constants, MMIO address default.
//   Sub-module mips_byte_ram: single-port 2**ADDR_BITS x 8, sync write, registered read,
//     read-before-write. Responder muxes load vs CPU port into it.
// TESTING
//   Load 4 bytes 11,22,33,44 (last on 44) -> load_count_out=4, cpu_hold_out=0 next edge,
//     then addr 0..3 read back 11,22,33,44 one cycle after each address.
//   Toggle load_valid_in with gaps -> only valid&ready cycles write; count matches accepts.
//   Load MEM_BYTES bytes with no last -> S_RUN after final byte, error_out=1.
//   S_RUN write A5 to addr 5 while reading addr 5 -> memdata_out=old byte, next read A5.
//   Write to addr 1<<ADDR_BITS -> RAM unchanged, memdata_out=0, error_out=1 stays set.
//   MIPS_MEM_MMIO_EN: write 5A to MMIO_ADDR -> io_out=5A, single io_strobe_out pulse;
//     reset_in low mid-load -> all outputs to reset values, load restarts at ptr 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory responder: bus-width defaults,
// the MMIO output-port address and the responder FSM / read-select encodings.
package mips_pkg;

  localparam int          DEF_BUS_WIDTH          = 32;
  localparam int          DEF_MEM_DATA_BUS_WIDTH = 8;
  localparam int          DEF_ADDR_BITS          = 10;
  localparam logic [31:0] DEF_MMIO_ADDR          = 32'hFFFF_FFFC;

  // Responder FSM: boot load, then CPU service until the next reset.
  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Source of the byte presented on memdata_out after each edge.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_IO   = 2'd2
  } rd_sel_t;

endpackage

// File: rtl/mips_byte_ram.sv
// Single-port byte RAM: synchronous write, registered read, read-before-write
// on a same-cycle write and read of the same index.
module mips_byte_ram
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_W    = DEF_MEM_DATA_BUS_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 we_in,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [DATA_W-1:0]    wdata_in,
  output logic [DATA_W-1:0]    rdata_out
);

  logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_W-1:0] r_rdata;

  // Write the addressed byte and register the pre-write contents of the same index.
  // NOTE: the array and its read register carry no reset so this maps onto a RAM
  // macro; the responder masks the read data until it is valid.
  always_ff @(posedge clk_in) begin
    if (we_in) begin
      r_mem[addr_in] <= wdata_in;
    end
    r_rdata <= r_mem[addr_in];
  end

  assign rdata_out = r_rdata;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS byte-wide bus. After reset it
// fills the byte RAM from a boot-load stream while holding the CPU in reset,
// then serves CPU reads/writes with a one-cycle registered read.
// Optional build macro: MIPS_MEM_MMIO_EN adds a byte output port at MMIO_ADDR.
module mips_mem_responder
  import mips_pkg::*;
#(
  parameter int                   BUS_WIDTH          = DEF_BUS_WIDTH,
  parameter int                   MEM_DATA_BUS_WIDTH = DEF_MEM_DATA_BUS_WIDTH,
  parameter int                   ADDR_BITS          = DEF_ADDR_BITS,
  parameter logic [BUS_WIDTH-1:0] MMIO_ADDR          = BUS_WIDTH'(DEF_MMIO_ADDR)
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          memwrite_in,
  input  logic [BUS_WIDTH-1:0]          addr_in,
  input  logic [MEM_DATA_BUS_WIDTH-1:0] writedata_in,
  output logic [MEM_DATA_BUS_WIDTH-1:0] memdata_out,
  input  logic                          load_valid_in,
  input  logic [MEM_DATA_BUS_WIDTH-1:0] load_data_in,
  input  logic                          load_last_in,
  output logic                          load_ready_out,
  output logic                          cpu_hold_out,
  output logic [ADDR_BITS:0]            load_count_out,
  output logic                          error_out,
  output logic [MEM_DATA_BUS_WIDTH-1:0] io_out,
  output logic                          io_strobe_out
);

`ifdef MIPS_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  state_t                        r_state, w_next_state;
  rd_sel_t                       r_rd_sel, w_rd_sel_next;
  logic [ADDR_BITS-1:0]          r_ptr;
  logic [ADDR_BITS:0]            r_count;
  logic                          r_error;

  logic                          w_accept;
  logic                          w_overflow;
  logic                          w_run_err;
  logic                          w_in_range;
  logic                          w_is_mmio;
  logic                          w_ram_we;
  logic [ADDR_BITS-1:0]          w_ram_addr;
  logic [MEM_DATA_BUS_WIDTH-1:0] w_ram_wdata;
  logic [MEM_DATA_BUS_WIDTH-1:0] w_ram_rdata;
  logic [MEM_DATA_BUS_WIDTH-1:0] w_io_rd;

  assign w_in_range = (addr_in[BUS_WIDTH-1:ADDR_BITS] == '0);
  assign w_is_mmio  = MMIO_EN && (addr_in == MMIO_ADDR);

  // Next state, load accept/overflow decode and RAM port mux (load stream vs CPU).
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_rd_sel_next = RD_ZERO;
    w_accept      = 1'b0;
    w_overflow    = 1'b0;
    w_run_err     = 1'b0;
    w_ram_we      = 1'b0;
    w_ram_addr    = r_ptr;
    w_ram_wdata   = load_data_in;
    case (r_state)
      S_LOAD: begin
        w_accept = load_valid_in;
        w_ram_we = load_valid_in;
        if (load_valid_in) begin
          if (load_last_in) begin
            w_next_state = S_RUN;
          end else if (r_ptr == '1) begin
            w_next_state = S_RUN;
            w_overflow   = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_ram_addr  = addr_in[ADDR_BITS-1:0];
        w_ram_wdata = writedata_in;
        if (w_in_range) begin
          w_ram_we      = memwrite_in;
          w_rd_sel_next = RD_RAM;
        end else if (w_is_mmio) begin
          w_rd_sel_next = RD_IO;
        end else begin
          w_run_err = 1'b1;
        end
      end
      default: w_next_state = S_LOAD;
    endcase
  end

  // State register, load pointer/count, read-source select and sticky error.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state  <= S_LOAD;
      r_rd_sel <= RD_ZERO;
      r_ptr    <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rd_sel <= w_rd_sel_next;
      if (w_accept) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (w_overflow || w_run_err) begin
        r_error <= 1'b1;
      end
    end
  end

  mips_byte_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (MEM_DATA_BUS_WIDTH)
  ) u_ram (
    .clk_in    (clk_in),
    .we_in     (w_ram_we),
    .addr_in   (w_ram_addr),
    .wdata_in  (w_ram_wdata),
    .rdata_out (w_ram_rdata)
  );

`ifdef MIPS_MEM_MMIO_EN
  logic [MEM_DATA_BUS_WIDTH-1:0] r_io;
  logic [MEM_DATA_BUS_WIDTH-1:0] r_io_rd;
  logic                          r_io_strobe;
  logic                          w_mmio_wr;

  assign w_mmio_wr = (r_state == S_RUN) && !w_in_range && w_is_mmio && memwrite_in;

  // MMIO output register, its one-cycle write strobe, and the pre-write
  // snapshot returned on an MMIO read.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_io        <= '0;
      r_io_rd     <= '0;
      r_io_strobe <= 1'b0;
    end else begin
      r_io_strobe <= w_mmio_wr;
      r_io_rd     <= r_io;
      if (w_mmio_wr) begin
        r_io <= writedata_in;
      end
    end
  end

  assign io_out        = r_io;
  assign io_strobe_out = r_io_strobe;
  assign w_io_rd       = r_io_rd;
`else
  assign io_out        = '0;
  assign io_strobe_out = 1'b0;
  assign w_io_rd       = '0;
`endif

  // Select the registered read byte: zero while loading or after a bad access.
  always_comb begin
    memdata_out = '0;
    case (r_rd_sel)
      RD_RAM:  memdata_out = w_ram_rdata;
      RD_IO:   memdata_out = w_io_rd;
      default: memdata_out = '0;
    endcase
  end

  assign load_ready_out = (r_state == S_LOAD);
  assign cpu_hold_out   = (r_state == S_LOAD);
  assign load_count_out = r_count;
  assign error_out      = r_error;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder. A behavioural model (byte array,
// load counter, sticky error) predicts every output after each clock edge.
module tb_mips_mem_responder;

  localparam int          AB        = 10;
  localparam int          MEM_BYTES = 1 << AB;
  localparam logic [31:0] MMIO_A    = 32'hFFFF_FFFC;
`ifdef MIPS_MEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk_in        = 1'b0;
  logic        reset_in      = 1'b0;
  logic        memwrite_in   = 1'b0;
  logic [31:0] addr_in       = '0;
  logic [7:0]  writedata_in  = '0;
  logic [7:0]  memdata_out;
  logic        load_valid_in = 1'b0;
  logic [7:0]  load_data_in  = '0;
  logic        load_last_in  = 1'b0;
  logic        load_ready_out;
  logic        cpu_hold_out;
  logic [AB:0] load_count_out;
  logic        error_out;
  logic [7:0]  io_out;
  logic        io_strobe_out;

  mips_mem_responder dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .memwrite_in    (memwrite_in),
    .addr_in        (addr_in),
    .writedata_in   (writedata_in),
    .memdata_out    (memdata_out),
    .load_valid_in  (load_valid_in),
    .load_data_in   (load_data_in),
    .load_last_in   (load_last_in),
    .load_ready_out (load_ready_out),
    .cpu_hold_out   (cpu_hold_out),
    .load_count_out (load_count_out),
    .error_out      (error_out),
    .io_out         (io_out),
    .io_strobe_out  (io_strobe_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [7:0] m_mem   [MEM_BYTES];
  bit         m_known [MEM_BYTES];
  bit         m_load;
  int         m_count;
  bit         m_err;
  logic [7:0] m_io;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load  = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
    m_io    = 8'h00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_memdata"}, 32'(memdata_out), 32'h0);
    check({tag, "_ready"},   32'(load_ready_out), 32'h1);
    check({tag, "_hold"},    32'(cpu_hold_out), 32'h1);
    check({tag, "_count"},   32'(load_count_out), 32'h0);
    check({tag, "_error"},   32'(error_out), 32'h0);
    check({tag, "_io"},      32'(io_out), 32'h0);
    check({tag, "_strobe"},  32'(io_strobe_out), 32'h0);
  endtask

  // Assert reset between edges; outputs must return to reset values at once.
  task automatic reset_now(input string tag);
    #2;
    reset_in = 1'b0;
    #1;
    check_reset_values(tag);
    @(negedge clk_in);
    reset_in = 1'b1;
    model_reset();
  endtask

  // One clock with the given load and CPU inputs; the model predicts the result.
  task automatic cycle(input bit lv, input logic [7:0] ld, input bit ll,
                       input bit we, input logic [31:0] a, input logic [7:0] wd);
    logic [7:0] exp_md;
    bit         md_known;
    bit         exp_strobe;
    int         idx;
    load_valid_in = lv;
    load_data_in  = ld;
    load_last_in  = ll;
    memwrite_in   = we;
    addr_in       = a;
    writedata_in  = wd;
    #1;
    check("ready_pre_edge", 32'(load_ready_out), 32'(m_load));
    exp_md     = 8'h00;
    md_known   = 1'b1;
    exp_strobe = 1'b0;
    if (m_load) begin
      if (lv) begin
        m_mem[m_count]   = ld;
        m_known[m_count] = 1'b1;
        m_count++;
        if (!ll && m_count == MEM_BYTES) m_err = 1'b1;
        if (ll || m_count == MEM_BYTES) m_load = 1'b0;
      end
    end else begin
      idx = int'(a[AB-1:0]);
      if (a[31:AB] == '0) begin
        exp_md   = m_mem[idx];
        md_known = m_known[idx];
        if (we) begin
          m_mem[idx]   = wd;
          m_known[idx] = 1'b1;
        end
      end else if (MMIO_ON && a == MMIO_A) begin
        exp_md = m_io;
        if (we) begin
          m_io       = wd;
          exp_strobe = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk_in);
    #1;
    if (md_known) check("memdata", 32'(memdata_out), 32'(exp_md));
    check("hold",   32'(cpu_hold_out), 32'(m_load));
    check("ready",  32'(load_ready_out), 32'(m_load));
    check("count",  32'(load_count_out), 32'(m_count));
    check("error",  32'(error_out), 32'(m_err));
    check("io",     32'(io_out), 32'(m_io));
    check("strobe", 32'(io_strobe_out), 32'(exp_strobe));
  endtask

  task automatic load_byte(input logic [7:0] d, input bit last);
    cycle(1'b1, d, last, 1'(($urandom) & 1), $urandom, 8'($urandom));
  endtask

  task automatic run_rd(input logic [31:0] a);
    cycle(1'(($urandom) & 1), 8'($urandom), 1'b0, 1'b0, a, 8'($urandom));
  endtask

  task automatic run_wr(input logic [31:0] a, input logic [7:0] d);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, a, d);
  endtask

  function automatic logic [31:0] rand_oor_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:AB] == '0) a[AB] = 1'b1;
    if (a == MMIO_A) a = 32'h0000_0400;
    return a;
  endfunction

  initial begin
    int accepted;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk_in);
    reset_in = 1'b1;

    // Boot load of four bytes, last flagged on the fourth, then read back.
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    load_byte(8'h44, 1'b1);
    for (int i = 0; i < 4; i++) run_rd(32'(i));

    // Read-before-write on the same index.
    run_wr(32'd5, 8'h77);
    run_wr(32'd5, 8'hA5);
    run_rd(32'd5);

    // MMIO port (an ordinary out-of-range address when the feature is absent).
    run_wr(MMIO_A, 8'h5A);
    run_rd(MMIO_A);
    run_rd(32'd0);

    // Out-of-range write: dropped, reads zero, sticky error.
    run_wr(32'(1 << AB), 8'hEE);
    run_rd(32'd0);
    run_rd(32'd1);

    // Reset during run, then reset during load: load restarts at index 0.
    reset_now("mid_run");
    load_byte(8'hD1, 1'b0);
    load_byte(8'hD2, 1'b0);
    load_byte(8'hD3, 1'b0);
    reset_now("mid_load");
    load_byte(8'hE1, 1'b0);
    load_byte(8'hE2, 1'b1);
    for (int i = 0; i < 3; i++) run_rd(32'(i));

    // Gapped random boot load, then randomized CPU traffic.
    reset_now("gap_load");
    accepted = 0;
    while (accepted < 20) begin
      if ($urandom_range(0, 2) != 0) begin
        accepted++;
        load_byte(8'($urandom), accepted == 20);
      end else begin
        cycle(1'b0, 8'($urandom), 1'(($urandom) & 1), 1'(($urandom) & 1),
              $urandom, 8'($urandom));
      end
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if (i >= 150 && $urandom_range(0, 9) == 0) a = rand_oor_addr();
      if (i >= 150 && $urandom_range(0, 19) == 0) a = MMIO_A;
      cycle(1'(($urandom) & 1), 8'($urandom), 1'(($urandom) & 1),
            1'(($urandom) & 1), a, 8'($urandom));
    end

    // Fill the whole RAM with no last flag: overflow ends the load with error.
    reset_now("full_load");
    for (int i = 0; i < MEM_BYTES; i++) load_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) run_rd(32'($urandom_range(0, MEM_BYTES - 1)));
    run_rd(32'(MEM_BYTES - 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
